// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: iterative shift-and-add unsigned multiplier sequencer.
// IDLE accepts a, b; RUN performs one add/shift per cycle; DONE holds the product
// until out_ready. Optional early termination is enabled by defining
// MULT_SEQ_EARLY_TERM_EN. Without it, RUN always lasts WIDTH cycles.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        count;
    logic                 accept;
    logic                 last_run;

    // Handshake qualifier and end-of-RUN detection
    always_comb begin
        accept = (state == IDLE) && in_valid;
`ifdef MULT_SEQ_EARLY_TERM_EN
        // Stop once the shifted multiplier has no set bits left; the count cap
        // keeps the WIDTH-cycle bound as a backstop.
        last_run = (mplier[WIDTH-1:1] == '0) || (count == CW'(WIDTH - 1));
`else
        last_run = (count == CW'(WIDTH - 1));
`endif
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)    state_nxt = RUN;
            RUN:  if (last_run)  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture in IDLE, one shift-and-add step per RUN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= '0;
        end else if (state == RUN) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

    // Outputs decoded from state; product is only exposed in DONE
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        product   = (state == DONE) ? acc : '0;
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed self-checking bench for mult_seq_ctrl (WIDTH=8).
module tb_mult_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_checks;
    int n_fail;

    mult_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [7:0] bv);
        int l;
`ifdef MULT_SEQ_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < 8; i++) if (bv[i]) l = i + 1;
`else
        l = (bv == 8'd0) ? 8 : 8;
`endif
        return l;
    endfunction

    // Counts edges after the handshake edge until out_valid, bounded.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    // One full transaction starting in IDLE, 0-cycle consumer stall.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] pe);
        int cyc;
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        tick();
        in_valid = 1'b0;
        a = 8'hxx;
        b = 8'hxx;
        chk("busy_after_accept", busy, 1);
        chk("product_zero_run", product, 0);
        wait_valid(cyc);
        chk("latency", cyc, exp_lat(bv));
        chk("product", product, pe);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("busy_drop", busy, 0);
        chk("product_zero_idle", product, 0);
    endtask

    initial begin
        int cyc;
        int seen;
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
        vecs[1] = '{a: 8'd0,   b: 8'd77,  p: 16'd0};
        vecs[2] = '{a: 8'd77,  b: 8'd0,   p: 16'd0};
        vecs[3] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
        vecs[5] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
        vecs[6] = '{a: 8'd200, b: 8'd7,   p: 16'd1400};
        vecs[7] = '{a: 8'd170, b: 8'd85,  p: 16'd14450};
        vecs[8] = '{a: 8'd9,   b: 8'd3,   p: 16'd27};
        vecs[9] = '{a: 8'd1,   b: 8'd128, p: 16'd128};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);

        // First accept on the first edge after reset release
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // out_ready held high throughout: DONE lasts exactly one cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'd13;
        b = 8'd11;
        tick();
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("eager_latency", cyc, exp_lat(8'd11));
        chk("eager_product", product, 143);
        tick();
        chk("eager_one_cycle", out_valid, 0);
        chk("eager_in_ready", in_ready, 1);
        out_ready = 1'b0;

        // Consumer stall: product and out_valid stable for 5 cycles
        in_valid = 1'b1;
        a = 8'd255;
        b = 8'd255;
        tick();
        in_valid = 1'b0;
        wait_valid(cyc);
        chk("stall_latency", cyc, exp_lat(8'd255));
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_product", product, 65025);
            chk("stall_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_release_idle", in_ready, 1);
        chk("stall_release_valid", out_valid, 0);

        // in_valid held with new operands during RUN/DONE; one-cycle bubble after DONE
        in_valid = 1'b1;
        a = 8'd13;
        b = 8'd11;
        tick();
        a = 8'd3;
        b = 8'd4;
        chk("hold_in_ready_run", in_ready, 0);
        wait_valid(cyc);
        chk("hold_latency", cyc, exp_lat(8'd11));
        chk("hold_product_first", product, 143);
        chk("hold_in_ready_done", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_bubble_idle", busy, 0);
        chk("hold_bubble_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("hold_second_accept", busy, 1);
        wait_valid(cyc);
        chk("hold_second_latency", cyc, exp_lat(8'd4));
        chk("hold_second_product", product, 12);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset 4 cycles after accept aborts the operation
        in_valid = 1'b1;
        a = 8'd200;
        b = 8'd7;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_product", product, 0);
        chk("abort_busy", busy, 0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid || product != 16'd0) seen++;
        end
        chk("abort_no_result", seen, 0);
        do_op(8'd2, 8'd5, 16'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  requester presents operands a, b.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  multiplicand, unsigned.
REQ-007 Port: b  input  WIDTH  multiplier, unsigned.
REQ-008 Port: out_valid  output  1  product is valid.
REQ-009 Port: out_ready  input  1  consumer accepts product.
REQ-010 Port: product  output  2*WIDTH  unsigned a*b.
REQ-011 Port: busy  output  1  high in RUN or DONE.

Function
REQ-012 The block SHALL be an iterative shift-and-add sequencer with three states: IDLE, RUN, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, latch a into mcand (2*WIDTH, zero-extended), b into mplier, clear acc and count, go to RUN.
REQ-014 RUN: per cycle, if mplier[0]=1 then acc <= acc + mcand (2*WIDTH-bit add, carry out discarded, cannot overflow); mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
REQ-015 RUN SHALL last exactly WIDTH cycles, then go to DONE (without REQ-030 feature).
REQ-016 DONE: out_valid=1, product=acc; on out_ready=1, go to IDLE at the next edge.
REQ-017 Latency: handshake at edge E0, out_valid first high after edge E0+WIDTH.
REQ-018 in_ready SHALL be 0 in RUN and DONE; a, b, in_valid are ignored there.
REQ-019 product and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 out_ready while not in DONE SHALL have no effect.
REQ-021 Same-cycle DONE handshake and new in_valid: new operands NOT accepted that cycle; earliest accept is the cycle after returning to IDLE (one-cycle bubble, no overlap).
REQ-022 product SHALL read 0 in IDLE and RUN; only DONE drives acc.
REQ-023 Operand 0 on either side SHALL yield product 0 with normal latency.
REQ-024 a=b=2^WIDTH-1 SHALL yield (2^WIDTH-1)^2 with no truncation.
REQ-025 busy = (state != IDLE).

Reset
REQ-026 Reset asserted SHALL immediately force state IDLE, independent of clk.
REQ-027 Reset values: in_ready=1 after release, out_valid=0, product=0, busy=0, acc/mcand/mplier/count=0.
REQ-028 Reset mid-RUN or mid-DONE SHALL abort the operation; the partial result is discarded and never presented.
REQ-029 First accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro MULT_SEQ_EARLY_TERM_EN: when defined, RUN SHALL exit to DONE after the cycle in which the updated mplier becomes 0; RUN length = max(1, position of MSB set in b + 1) cycles; b=0 takes 1 RUN cycle.
REQ-031 When MULT_SEQ_EARLY_TERM_EN is undefined, RUN length SHALL be fixed at WIDTH cycles for all operands; product values identical in both builds.

Verification (WIDTH=8)
REQ-032 Accept a=13,b=11 at edge E0, out_ready=1 -> out_valid high after E0+8, product=143, one cycle, then in_ready=1.
REQ-033 a=255,b=255, out_ready held 0 for 5 cycles -> product=65025 stable all 5 cycles, out_valid held; release -> IDLE next edge.
REQ-034 in_valid held high with new operands during RUN/DONE -> none accepted; second op (a=3,b=4) accepted only cycle after first handshake, product=12.
REQ-035 Reset pulse 4 cycles after accept of a=200,b=7 -> out_valid=0, product=0 immediately; no result ever emitted for that op; next op a=2,b=5 -> 10.
REQ-036 With MULT_SEQ_EARLY_TERM_EN: a=9,b=3 -> out_valid after E0+2, product=27; b=0 -> after E0+1, product=0; b=128 -> after E0+8.
